// File: rtl/oclib_async_req_ack_mux_to_ready_valid_pkg.sv
// Shared types and helpers for the async req/ack to ready/valid merge block.
// Imported by the channel receiver and the top-level mux.
package oclib_async_req_ack_mux_to_ready_valid_pkg;

  typedef enum logic {
    RtzHandshake,
    ToggleHandshake
  } handshake_e;

  typedef enum logic {
    ChanIdle,
    ChanAcked
  } chan_state_e;

  // A single channel still needs a 1-bit channel tag on the output.
  function automatic int chan_id_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic handshake_e handshake_mode(input int two_phase);
    return (two_phase != 0) ? ToggleHandshake : RtzHandshake;
  endfunction

endpackage

// File: rtl/oclib_async_req_ack_chan_rx.sv
// One asynchronous req/ack receiver: synchroniser, handshake FSM and a small FIFO.
// The FSM only acknowledges once the payload is safely written into the FIFO.
module oclib_async_req_ack_chan_rx
  import oclib_async_req_ack_mux_to_ready_valid_pkg::*;
#(
  parameter int         Width      = 8,
  parameter int         Depth      = 4,
  parameter int         SyncStages = 2,
  parameter handshake_e Mode       = RtzHandshake
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [Width-1:0] data,
  input  logic             req,
  output logic             ack,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic             not_empty
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [Width:0]     sync_q;
  logic               req_sync;
  logic [Width-1:0]   data_sync;
  logic               wr_en;
  logic               full;

  logic [Width-1:0]   mem [Depth];
  logic [PtrW-1:0]    wr_ptr;
  logic [PtrW-1:0]    rd_ptr;
  logic [CntW-1:0]    count;

  // Req and data share the same stages, so the data is settled when req_sync rises.
  oclib_synchronizer #(
    .Width  (Width + 1),
    .Stages (SyncStages)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     ({req, data}),
    .q     (sync_q)
  );

  assign req_sync  = sync_q[Width];
  assign data_sync = sync_q[Width-1:0];

  assign full      = (count == CntW'(Depth));
  assign not_empty = (count != '0);
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= data_sync;
  end

  if (Mode == RtzHandshake) begin : g_rtz
    chan_state_e state;
    chan_state_e state_next;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ChanIdle;
      else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      unique case (state)
        ChanIdle: begin
          if (req_sync && !full) begin
            wr_en      = 1'b1;
            state_next = ChanAcked;
          end
        end
        ChanAcked: begin
          if (!req_sync) state_next = ChanIdle;
        end
      endcase
    end

    assign ack = (state == ChanAcked);
  end else begin : g_toggle
    logic ack_q;
    logic ack_next;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) ack_q <= 1'b0;
      else        ack_q <= ack_next;
    end

    // A pending event is any mismatch between the synchronised req and our ack.
    always_comb begin
      ack_next = ack_q;
      wr_en    = 1'b0;
      if ((req_sync != ack_q) && !full) begin
        wr_en    = 1'b1;
        ack_next = req_sync;
      end
    end

    assign ack = ack_q;
  end

endmodule

// File: rtl/oclib_synchronizer.sv
// Multi-flop synchroniser with asynchronous active-low clear.
// Used for req/data capture and for reset deassertion.
module oclib_synchronizer #(
  parameter int Width  = 1,
  parameter int Stages = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Stages-1:0][Width-1:0] stage;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage <= '0;
    end else begin
      stage <= {stage[Stages-2:0], d};
    end
  end

  assign q = stage[Stages-1];

endmodule

// File: rtl/oclib_async_req_ack_mux_to_ready_valid.sv
// Merges several async req/ack senders into one ready/valid stream tagged with its source channel.
// Per-channel receivers fill FIFOs; a round-robin arbiter drains them into one output register.
module oclib_async_req_ack_mux_to_ready_valid
  import oclib_async_req_ack_mux_to_ready_valid_pkg::*;
#(
  parameter int  Width      = 8,
  parameter int  Channels   = 2,
  parameter int  Depth      = 4,
  parameter int  TwoPhase   = 0,
  parameter int  SyncStages = 2,
  localparam int ChanW      = chan_id_width(Channels)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [Channels*Width-1:0] inData,
  input  logic [Channels-1:0]       inReq,
  output logic [Channels-1:0]       inAck,
  output logic [Width-1:0]          outData,
  output logic [ChanW-1:0]          outChan,
  output logic                      outValid,
  input  logic                      outReady
);

  localparam handshake_e Mode = handshake_mode(TwoPhase);

  logic                rst_n;
  logic [Channels-1:0] not_empty;
  logic [Channels-1:0] rd_en;
  logic [Width-1:0]    rd_data [Channels];
  logic [ChanW-1:0]    ptr;
  logic [ChanW-1:0]    pick;
  logic                found;
  logic                load;

  // Reset asserts asynchronously but releases only after SyncStages clean clock edges.
  oclib_synchronizer #(
    .Width  (1),
    .Stages (SyncStages)
  ) u_rst_sync (
    .clock (clock),
    .reset (reset),
    .d     (1'b1),
    .q     (rst_n)
  );

  for (genvar c = 0; c < Channels; c++) begin : g_chan
    oclib_async_req_ack_chan_rx #(
      .Width      (Width),
      .Depth      (Depth),
      .SyncStages (SyncStages),
      .Mode       (Mode)
    ) u_chan (
      .clock     (clock),
      .reset     (rst_n),
      .data      (inData[c*Width +: Width]),
      .req       (inReq[c]),
      .ack       (inAck[c]),
      .rd_en     (rd_en[c]),
      .rd_data   (rd_data[c]),
      .not_empty (not_empty[c])
    );
  end

  // Scan from the pointer upward, wrapping, and take the first channel with data.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < Channels; i++) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= Channels) idx = idx - Channels;
      if (!found && not_empty[idx]) begin
        found = 1'b1;
        pick  = ChanW'(idx);
      end
    end
  end

  assign load = (!outValid || outReady) && found;

  always_comb begin
    rd_en = '0;
    if (load) rd_en[pick] = 1'b1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      outValid <= 1'b0;
      outData  <= '0;
      outChan  <= '0;
      ptr      <= '0;
    end else if (load) begin
      outValid <= 1'b1;
      outData  <= rd_data[pick];
      outChan  <= pick;
      ptr      <= (int'(pick) == Channels - 1) ? '0 : pick + ChanW'(1);
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oclib_async_req_ack_mux_to_ready_valid.sv
// Directed and randomised checks of the async req/ack merge: latency, backpressure,
// round-robin fairness, two-phase handshake, output hold and mid-stream reset.
module tb_oclib_async_req_ack_mux_to_ready_valid;

  int checks   = 0;
  int failures = 0;

  logic        clock = 1'b0;
  logic        rst_n = 1'b1;

  // Four-phase, two-channel instance
  logic [15:0] in_data  = '0;
  logic [1:0]  in_req   = '0;
  logic [1:0]  in_ack;
  logic [7:0]  out_data;
  logic        out_chan;
  logic        out_valid;
  logic        out_ready = 1'b1;

  // Two-phase, one-channel instance
  logic [7:0]  tp_data  = '0;
  logic        tp_req   = 1'b0;
  logic        tp_ack;
  logic [7:0]  tp_out_data;
  logic        tp_out_chan;
  logic        tp_out_valid;
  logic        tp_out_ready = 1'b1;

  // Accepted beats, recorded by the monitor
  logic [7:0]  rx_data [$];
  logic        rx_chan [$];
  logic [7:0]  tp_rx   [$];

  always #5 clock = ~clock;

  oclib_async_req_ack_mux_to_ready_valid #(
    .Width(8), .Channels(2), .Depth(4), .TwoPhase(0), .SyncStages(2)
  ) dut (
    .clock    (clock),
    .reset    (rst_n),
    .inData   (in_data),
    .inReq    (in_req),
    .inAck    (in_ack),
    .outData  (out_data),
    .outChan  (out_chan),
    .outValid (out_valid),
    .outReady (out_ready)
  );

  oclib_async_req_ack_mux_to_ready_valid #(
    .Width(8), .Channels(1), .Depth(4), .TwoPhase(1), .SyncStages(2)
  ) dut_tp (
    .clock    (clock),
    .reset    (rst_n),
    .inData   (tp_data),
    .inReq    (tp_req),
    .inAck    (tp_ack),
    .outData  (tp_out_data),
    .outChan  (tp_out_chan),
    .outValid (tp_out_valid),
    .outReady (tp_out_ready)
  );

  // Inputs change at posedge+1, so values seen here hold through the next accepting edge.
  always @(negedge clock) begin
    if (rst_n && out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_chan.push_back(out_chan);
    end
    if (rst_n && tp_out_valid && tp_out_ready) tp_rx.push_back(tp_out_data);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ack(input int c, input logic v, input int budget, output bit ok);
    for (int n = 0; n < budget && in_ack[c] !== v; n++) tick();
    ok = (in_ack[c] === v);
  endtask

  // Full four-phase transfer; data is made stable one clock before the req edge.
  task automatic hs4(input int c, input logic [7:0] d, output bit ok);
    bit ok_hi, ok_lo;
    in_data[c*8 +: 8] = d;
    tick();
    in_req[c] = 1'b1;
    wait_ack(c, 1'b1, 40, ok_hi);
    in_req[c] = 1'b0;
    wait_ack(c, 1'b0, 40, ok_lo);
    ok = ok_hi && ok_lo;
  endtask

  initial begin
    bit          ok, ok0, ok1;
    int          acked0, acked1;
    logic [7:0]  exp0 [$];
    logic [7:0]  exp1 [$];
    logic [7:0]  d;

    // ---------------- reset values
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_ack",   32'(in_ack),    32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data",  32'(out_data),  32'h0);
    check("rst_chan",  32'(out_chan),  32'h0);
    check("rst_tp_ack", 32'(tp_ack),   32'h0);
    rst_n = 1'b1;
    repeat (5) tick();

    // ---------------- single transfer latency (SyncStages=2)
    in_data[7:0] = 8'h5A;
    tick();
    in_req[0] = 1'b1;
    repeat (2) tick();
    check("lat_ack_early", 32'(in_ack[0]), 32'h0);
    tick();
    check("lat_ack",         32'(in_ack[0]), 32'h1);
    check("lat_valid_early", 32'(out_valid), 32'h0);
    tick();
    check("lat_valid", 32'(out_valid), 32'h1);
    check("lat_data",  32'(out_data),  32'h5A);
    check("lat_chan",  32'(out_chan),  32'h0);
    in_req[0] = 1'b0;
    wait_ack(0, 1'b0, 40, ok);
    check("lat_ack_drop", 32'(ok), 32'h1);
    repeat (4) tick();
    check("lat_rx_count", 32'(rx_data.size()), 32'd1);
    if (rx_data.size() > 0) check("lat_rx_data", 32'(rx_data[0]), 32'h5A);
    rx_data.delete();
    rx_chan.delete();

    // ---------------- backpressure: capacity is the output register plus Depth FIFO entries
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hs4(0, 8'(i), ok);
      check($sformatf("bp_ack_%0d", i), 32'(ok), 32'h1);
    end
    repeat (2) tick();
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(out_valid), 32'h1);
      check("hold_data",  32'(out_data),  32'h0);
      check("hold_chan",  32'(out_chan),  32'h0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("next_beat_valid", 32'(out_valid), 32'h1);
    check("next_beat_data",  32'(out_data),  32'h1);
    hs4(0, 8'd5, ok);
    check("bp_ack_5", 32'(ok), 32'h1);
    in_data[7:0] = 8'd6;
    tick();
    in_req[0] = 1'b1;
    repeat (20) tick();
    check("bp_withheld", 32'(in_ack[0]), 32'h0);
    out_ready = 1'b1;
    wait_ack(0, 1'b1, 40, ok);
    check("bp_released", 32'(ok), 32'h1);
    in_req[0] = 1'b0;
    wait_ack(0, 1'b0, 40, ok);
    check("bp_release_drop", 32'(ok), 32'h1);
    repeat (12) tick();
    check("bp_rx_count", 32'(rx_data.size()), 32'd7);
    for (int i = 0; i < rx_data.size() && i < 7; i++) begin
      check($sformatf("bp_order_%0d", i), 32'(rx_data[i]), 32'(i));
      check($sformatf("bp_chan_%0d", i), 32'(rx_chan[i]), 32'h0);
    end
    rx_data.delete();
    rx_chan.delete();

    // ---------------- both channels streaming, random payloads
    acked0 = 0;
    acked1 = 0;
    for (int i = 0; i < 6; i++) begin
      exp0.push_back(8'($urandom));
      exp1.push_back(8'($urandom));
    end
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          hs4(0, exp0[i], ok0);
          if (ok0) acked0++;
        end
      end
      begin
        for (int i = 0; i < 6; i++) begin
          hs4(1, exp1[i], ok1);
          if (ok1) acked1++;
        end
      end
    join
    repeat (10) tick();
    check("rr_acked0", 32'(acked0), 32'd6);
    check("rr_acked1", 32'(acked1), 32'd6);
    check("rr_rx_count", 32'(rx_data.size()), 32'd12);
    for (int i = 0; i < rx_data.size(); i++) begin
      if (i > 0) check($sformatf("rr_alternate_%0d", i), 32'(rx_chan[i] != rx_chan[i-1]), 32'h1);
      if (rx_chan[i] == 1'b0) begin
        check($sformatf("rr_ch0_present_%0d", i), 32'(exp0.size() > 0), 32'h1);
        if (exp0.size() > 0) check($sformatf("rr_ch0_data_%0d", i), 32'(rx_data[i]), 32'(exp0.pop_front()));
      end else begin
        check($sformatf("rr_ch1_present_%0d", i), 32'(exp1.size() > 0), 32'h1);
        if (exp1.size() > 0) check($sformatf("rr_ch1_data_%0d", i), 32'(rx_data[i]), 32'(exp1.pop_front()));
      end
    end
    check("rr_ch0_leftover", 32'(exp0.size()), 32'd0);
    check("rr_ch1_leftover", 32'(exp1.size()), 32'd0);
    rx_data.delete();
    rx_chan.delete();

    // ---------------- two-phase toggle handshake on the single-channel instance
    for (int i = 1; i <= 8; i++) begin
      tp_data = 8'(i);
      tick();
      tp_req = ~tp_req;
      for (int n = 0; n < 40 && tp_ack !== tp_req; n++) tick();
      check($sformatf("tp_ack_track_%0d", i), 32'(tp_ack), 32'(tp_req));
    end
    repeat (10) tick();
    check("tp_rx_count", 32'(tp_rx.size()), 32'd8);
    for (int i = 0; i < tp_rx.size() && i < 8; i++)
      check($sformatf("tp_order_%0d", i), 32'(tp_rx[i]), 32'(i + 1));

    // ---------------- reset mid-stream with FIFO contents and a raised ack
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = 8'hA0 + 8'(i);
      hs4(0, d, ok);
      check($sformatf("mid_fill_%0d", i), 32'(ok), 32'h1);
    end
    in_data[15:8] = 8'hB0;
    tick();
    in_req[1] = 1'b1;
    wait_ack(1, 1'b1, 40, ok);
    check("mid_ack_high", 32'(ok), 32'h1);
    check("mid_valid_pre", 32'(out_valid), 32'h1);
    rst_n     = 1'b0;
    in_req[1] = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_ack",   32'(in_ack),    32'h0);
    check("mid_rst_data",  32'(out_data),  32'h0);
    repeat (3) tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    rx_data.delete();
    rx_chan.delete();
    repeat (30) tick();
    check("mid_no_spurious", 32'(rx_data.size()), 32'd0);
    check("mid_idle_valid",  32'(out_valid),      32'h0);
    check("mid_idle_ack",    32'(in_ack),         32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
